// File: rtl/ram_dp.sv
// Single-clock simple dual-port RAM with byte enables, a self-clearing
// sequencer (reset release or init pulse), configurable read latency and read-during-write mode.
module ram_dp #(
  parameter int BIT = 16,
  parameter int SZB = 4,
  parameter int RDW = 0,
  parameter int LAT = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               init,
  output logic               busy,
  input  logic               we,
  input  logic [BIT/8-1:0]   be,
  input  logic [SZB-1:0]     waddr,
  input  logic [BIT-1:0]     d,
  input  logic               re,
  input  logic [SZB-1:0]     raddr,
  output logic [BIT-1:0]     q,
  output logic               q_valid
);

  localparam int NB    = BIT / 8;
  localparam int DEPTH = 1 << SZB;
  localparam logic [SZB-1:0] CNT_MAX = {SZB{1'b1}};
  localparam logic [SZB-1:0] CNT_ONE = SZB'(1'b1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t         state_r;
  state_t         state_nx_s;
  logic [SZB-1:0] cnt_r;
  logic [SZB-1:0] cnt_nx_s;

  logic [BIT-1:0] mem_r [DEPTH];

  logic           clr_we_s;
  logic           wr_acc_s;
  logic           rd_acc_s;
  logic [BIT-1:0] wr_word_s;
  logic [BIT-1:0] rd_word_s;
  logic [BIT-1:0] q_r;
  logic           qv_r;

  // Byte-lane merge: lanes with en set take the new byte, others keep the old one.
  function automatic logic [BIT-1:0] merge_bytes(
    input logic [BIT-1:0] old_w,
    input logic [BIT-1:0] new_w,
    input logic [NB-1:0]  en
  );
    logic [BIT-1:0] res;
    res = old_w;
    for (int k = 0; k < NB; k++) begin
      if (en[k]) begin
        res[8*k +: 8] = new_w[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_w[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Sequencer state and clear counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= CLEAR;
      cnt_r   <= {SZB{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next-state logic: CLEAR walks every address once, IDLE waits for init.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      CLEAR: begin
        cnt_nx_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_MAX) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = CLEAR;
        end
      end
      IDLE: begin
        if (init) begin
          state_nx_s = CLEAR;
          cnt_nx_s   = {SZB{1'b0}};
        end else begin
          state_nx_s = IDLE;
          cnt_nx_s   = cnt_r;
        end
      end
      default: begin
        state_nx_s = CLEAR;
        cnt_nx_s   = {SZB{1'b0}};
      end
    endcase
  end

  // Clear writes are held off while reset is asserted so the array is only touched by the sequence proper.
  assign clr_we_s  = (state_r == CLEAR) && reset;
  assign wr_acc_s  = (state_r == IDLE) && we;
  assign rd_acc_s  = (state_r == IDLE) && re;
  assign wr_word_s = merge_bytes(mem_r[waddr], d, be);
  assign busy      = (state_r == CLEAR);

  // Same-address bypass returns the merged word only in write-first mode.
  always_comb begin
    rd_word_s = mem_r[raddr];
    if ((RDW == 1) && wr_acc_s && (waddr == raddr)) begin
      rd_word_s = wr_word_s;
    end else begin
      rd_word_s = mem_r[raddr];
    end
  end

  // Storage array: no reset, zeroed only by the clear sequence.
  always_ff @(posedge clock) begin
    if (clr_we_s) begin
      mem_r[cnt_r] <= {BIT{1'b0}};
    end else if (wr_acc_s) begin
      mem_r[waddr] <= wr_word_s;
    end
  end

  generate
    if (LAT == 2) begin : g_lat2
      logic [BIT-1:0] p_r;
      logic           pv_r;

      // Two-stage read path: capture stage then output register.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          p_r  <= {BIT{1'b0}};
          pv_r <= 1'b0;
          q_r  <= {BIT{1'b0}};
          qv_r <= 1'b0;
        end else begin
          pv_r <= rd_acc_s;
          if (rd_acc_s) begin
            p_r <= rd_word_s;
          end
          qv_r <= pv_r;
          if (pv_r) begin
            q_r <= p_r;
          end
        end
      end
    end else begin : g_lat1
      // Single-stage read path; q holds between accepted reads.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          q_r  <= {BIT{1'b0}};
          qv_r <= 1'b0;
        end else begin
          qv_r <= rd_acc_s;
          if (rd_acc_s) begin
            q_r <= rd_word_s;
          end
        end
      end
    end
  endgenerate

  assign q       = q_r;
  assign q_valid = qv_r;

endmodule

// File: tb/tb_ram_dp.sv
// Directed bench for ram_dp: instance A is read-first/latency 1, instance B is
// write-first/latency 2; both share all inputs.
module tb_ram_dp;

  logic        clock;
  logic        reset;
  logic        init;
  logic        we;
  logic        re;
  logic [1:0]  be;
  logic [3:0]  waddr;
  logic [3:0]  raddr;
  logic [15:0] d;
  logic        busy_a, busy_b;
  logic        qv_a, qv_b;
  logic [15:0] q_a, q_b;

  logic [15:0] model [16];
  int n_err    = 0;
  int n_checks = 0;
  int n;

  ram_dp #(.BIT(16), .SZB(4), .RDW(0), .LAT(1)) dut_a (
    .clock(clock), .reset(reset), .init(init), .busy(busy_a),
    .we(we), .be(be), .waddr(waddr), .d(d),
    .re(re), .raddr(raddr), .q(q_a), .q_valid(qv_a)
  );

  ram_dp #(.BIT(16), .SZB(4), .RDW(1), .LAT(2)) dut_b (
    .clock(clock), .reset(reset), .init(init), .busy(busy_b),
    .we(we), .be(be), .waddr(waddr), .d(d),
    .re(re), .raddr(raddr), .q(q_b), .q_valid(qv_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [3:0] a, input logic [15:0] val, input logic [1:0] bev);
    waddr = a; d = val; be = bev; we = 1'b1;
    tick();
    we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (bev[k]) model[a][8*k +: 8] = val[8*k +: 8];
    end
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy_a && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  // Continuous reads 0..15 with re held high, checking both latencies against the model.
  task automatic read_sweep(input string tag);
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        re = 1'b1; raddr = 4'(i);
      end else begin
        re = 1'b0;
      end
      tick();
      if (i < 16) begin
        chk({tag, "_qv_a"}, 32'(qv_a), 32'd1);
        chk({tag, "_q_a"}, 32'(q_a), 32'(model[i]));
      end else begin
        chk({tag, "_qv_a_idle"}, 32'(qv_a), 32'd0);
      end
      if (i >= 1 && i <= 16) begin
        chk({tag, "_qv_b"}, 32'(qv_b), 32'd1);
        chk({tag, "_q_b"}, 32'(q_b), 32'(model[i-1]));
      end else begin
        chk({tag, "_qv_b_idle"}, 32'(qv_b), 32'd0);
      end
    end
    re = 1'b0;
  endtask

  initial begin
    reset = 1'b0; init = 1'b0; we = 1'b0; re = 1'b0;
    be = 2'b00; waddr = 4'd0; raddr = 4'd0; d = 16'h0000;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;

    repeat (3) tick();
    chk("rst_busy_a", 32'(busy_a), 32'd1);
    chk("rst_busy_b", 32'(busy_b), 32'd1);
    chk("rst_q_a", 32'(q_a), 32'd0);
    chk("rst_qv_a", 32'(qv_a), 32'd0);
    chk("rst_q_b", 32'(q_b), 32'd0);
    chk("rst_qv_b", 32'(qv_b), 32'd0);

    reset = 1'b1;
    count_busy(n);
    chk("busy_len_release", 32'(n), 32'd16);
    chk("busy_b_after_clear", 32'(busy_b), 32'd0);
    read_sweep("clr0");

    // Partial byte write then read, both latencies.
    write_word(4'd7, 16'hA5C3, 2'b01);
    re = 1'b1; raddr = 4'd7;
    tick();
    re = 1'b0;
    chk("be01_q_a", 32'(q_a), 32'h00C3);
    chk("be01_qv_a", 32'(qv_a), 32'd1);
    chk("be01_qv_b_early", 32'(qv_b), 32'd0);
    tick();
    chk("be01_qv_a_drop", 32'(qv_a), 32'd0);
    chk("be01_q_a_hold", 32'(q_a), 32'h00C3);
    chk("be01_qv_b", 32'(qv_b), 32'd1);
    chk("be01_q_b", 32'(q_b), 32'h00C3);
    tick();
    chk("be01_qv_b_drop", 32'(qv_b), 32'd0);
    chk("be01_q_b_hold", 32'(q_b), 32'h00C3);

    // Same-address read during write.
    write_word(4'd3, 16'h1111, 2'b11);
    we = 1'b1; waddr = 4'd3; d = 16'h2222; be = 2'b11; re = 1'b1; raddr = 4'd3;
    tick();
    we = 1'b0; re = 1'b0;
    model[3] = 16'h2222;
    chk("rdw_old_q_a", 32'(q_a), 32'h1111);
    tick();
    chk("rdw_new_q_b", 32'(q_b), 32'h2222);
    re = 1'b1; raddr = 4'd3;
    tick();
    re = 1'b0;
    chk("rdw_later_q_a", 32'(q_a), 32'h2222);
    tick();
    chk("rdw_later_q_b", 32'(q_b), 32'h2222);

    // Same-address read during a partial write.
    we = 1'b1; waddr = 4'd5; d = 16'hBEEF; be = 2'b10; re = 1'b1; raddr = 4'd5;
    tick();
    we = 1'b0; re = 1'b0;
    model[5] = 16'hBE00;
    chk("rdw_part_q_a", 32'(q_a), 32'h0000);
    tick();
    chk("rdw_part_q_b", 32'(q_b), 32'hBE00);
    write_word(4'd5, 16'hFFFF, 2'b00);

    re = 1'b1; raddr = 4'd7;
    tick();
    re = 1'b0;
    tick();
    tick();
    chk("pre_rst_q_a", 32'(q_a), 32'h00C3);
    chk("pre_rst_q_b", 32'(q_b), 32'h00C3);

    // Reset in the middle of a clear.
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("init_busy", 32'(busy_a), 32'd1);
    repeat (9) tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_a), 32'd1);
    chk("mid_rst_q_a", 32'(q_a), 32'd0);
    chk("mid_rst_qv_a", 32'(qv_a), 32'd0);
    chk("mid_rst_q_b", 32'(q_b), 32'd0);
    chk("mid_rst_qv_b", 32'(qv_b), 32'd0);
    tick();
    chk("mid_rst_q_a_2", 32'(q_a), 32'd0);
    reset = 1'b1;
    count_busy(n);
    chk("busy_len_after_abort", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;

    // Fill then streaming read.
    for (int i = 0; i < 16; i++) write_word(4'(i), 16'(i * 16'h0101), 2'b11);
    read_sweep("fill");

    // init with a read in flight, write/read attempts during busy.
    init = 1'b1; re = 1'b1; raddr = 4'd4;
    tick();
    init = 1'b0; re = 1'b0;
    chk("inflight_busy", 32'(busy_a), 32'd1);
    chk("inflight_q_a", 32'(q_a), 32'h0404);
    chk("inflight_qv_a", 32'(qv_a), 32'd1);
    chk("inflight_qv_b_early", 32'(qv_b), 32'd0);
    n = 0;
    while (busy_a && n < 40) begin
      if (n == 15) begin
        we = 1'b1; waddr = 4'd0; d = 16'hFFFF; be = 2'b11; re = 1'b1; raddr = 4'd0;
      end
      tick();
      we = 1'b0; re = 1'b0;
      n++;
      if (n == 1) begin
        chk("inflight_q_b", 32'(q_b), 32'h0404);
        chk("inflight_qv_b", 32'(qv_b), 32'd1);
      end
    end
    chk("busy_len_init", 32'(n), 32'd16);
    chk("busy_read_dropped_a", 32'(qv_a), 32'd0);
    tick();
    chk("busy_read_dropped_b", 32'(qv_b), 32'd0);
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    read_sweep("after_init");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
